operand_bus_arbiter: RTL and testbench

- Shares one 32-bit operand bus among four requesters (r0..r3) using round-robin arbitration with bounded bursts.
- Drives the 2-bit `select` of the downstream 4:1 operand mux.
- Registers the chosen operand and presents it with a valid/ready handshake to the consuming datapath stage.
- Returns a one-cycle `ack` to the served requester so it can advance its source (e.g. pop a FIFO).

---
 rtl/operand_bus_arbiter.sv | 119 +++++++++++
 tb/tb_operand_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter sharing one operand bus among four requesters with bounded bursts.
// The chosen operand is registered and held under a valid/ready handshake; ack pulses to the served requester.
module operand_bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand,
    output logic             out_valid,
    output logic [1:0]       select,
    output logic [3:0]       grant,
    output logic [3:0]       ack
);

    typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [1:0]       select_q, select_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic [1:0]       winner;
    logic [1:0]       start_ptr;

    // First set request bit at or after base, wrapping; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        operand_d   = operand_q;
        select_d    = select_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        winner      = last_q;
        start_ptr   = ptr_q;

        case (state_q)
            ARB: begin
                if (req == 4'b0000) begin
                    burst_cnt_d = 4'd0;
                end else begin
                    if (req[last_q] && (burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_LIMIT)) begin
                        winner      = last_q;
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        // A finished burst hands priority to the requester after the last one served.
                        start_ptr   = (burst_cnt_q != 4'd0) ? last_q + 2'd1 : ptr_q;
                        ptr_d       = start_ptr;
                        winner      = rr_pick(req, start_ptr);
                        burst_cnt_d = 4'd1;
                    end
                    select_d = winner;
                    grant_d  = 4'b0001 << winner;
                    last_d   = winner;
                    state_d  = HOLD;
                    case (winner)
                        2'd0:    operand_d = r0;
                        2'd1:    operand_d = r1;
                        2'd2:    operand_d = r2;
                        default: operand_d = r3;
                    endcase
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ARB;
                    grant_d = 4'b0000;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            operand_q   <= '0;
            select_q    <= 2'd0;
            grant_q     <= 4'b0000;
            ptr_q       <= 2'd0;
            last_q      <= 2'd0;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            select_q    <= select_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign operand   = operand_q;
    assign out_valid = (state_q == HOLD);
    assign select    = select_q;
    assign grant     = grant_q;
    assign ack       = grant_q & {4{out_valid & out_ready}};

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Bench for operand_bus_arbiter: directed vector table, burst-order sequences and random traffic
// against a reference model, with two instances (BURST_MAX=4 and BURST_MAX=1) sharing the inputs.
module tb_operand_bus_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [W-1:0] r0, r1, r2, r3;
    logic         out_ready;

    logic [W-1:0] op4, op1;
    logic         v4, v1;
    logic [1:0]   s4, s1;
    logic [3:0]   g4, g1, a4, a1;

    always #5 clk = ~clk;

    operand_bus_arbiter #(.WIDTH(W), .BURST_MAX(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .out_ready(out_ready), .operand(op4), .out_valid(v4), .select(s4), .grant(g4), .ack(a4)
    );

    operand_bus_arbiter #(.WIDTH(W), .BURST_MAX(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .out_ready(out_ready), .operand(op1), .out_valid(v1), .select(s1), .grant(g1), .ack(a1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-instance arbitration state, stepped once per rising edge.
    int           m_bm    [2] = '{4, 1};
    logic         m_hold  [2];
    logic [W-1:0] m_op    [2];
    int           m_sel   [2];
    int           m_ptr   [2];
    int           m_last  [2];
    int           m_burst [2];
    bit           mon_en = 1'b0;

    function automatic logic [W-1:0] rval(input int idx);
        case (idx)
            0:       return r0;
            1:       return r1;
            2:       return r2;
            default: return r3;
        endcase
    endfunction

    task automatic model_step(input int i);
        int w;
        w = -1;
        if (reset) begin
            m_hold[i] = 1'b0; m_op[i] = '0; m_sel[i] = 0;
            m_ptr[i] = 0; m_last[i] = 0; m_burst[i] = 0;
        end else if (!m_hold[i]) begin
            if (req != 4'b0000) begin
                if (req[m_last[i]] && m_burst[i] > 0 && m_burst[i] < m_bm[i]) begin
                    w = m_last[i];
                    m_burst[i] = m_burst[i] + 1;
                end else begin
                    if (m_burst[i] > 0) m_ptr[i] = (m_last[i] + 1) % 4;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req[(m_ptr[i] + k) % 4]) w = (m_ptr[i] + k) % 4;
                    m_burst[i] = 1;
                end
                m_hold[i] = 1'b1;
                m_sel[i]  = w;
                m_last[i] = w;
                m_op[i]   = rval(w);
            end else begin
                m_burst[i] = 0;
            end
        end else if (out_ready) begin
            m_hold[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1'b0; m_op[i] = '0; m_sel[i] = 0;
            m_ptr[i] = 0; m_last[i] = 0; m_burst[i] = 0;
        end
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic mon_cmp(input int i, input logic v, input logic [1:0] s, input logic [3:0] g,
                           input logic [3:0] a, input logic [W-1:0] op);
        logic [3:0] eg, ea;
        string      tag;
        tag = (i == 0) ? "b4" : "b1";
        eg  = m_hold[i] ? 4'(1 << m_sel[i]) : 4'b0000;
        ea  = (m_hold[i] && out_ready) ? eg : 4'b0000;
        check({tag, " valid"},   32'(v),  32'(m_hold[i]));
        check({tag, " select"},  32'(s),  32'(m_sel[i]));
        check({tag, " grant"},   32'(g),  32'(eg));
        check({tag, " ack"},     32'(a),  32'(ea));
        check({tag, " operand"}, op,      m_op[i]);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            mon_cmp(0, v4, s4, g4, a4, op4);
            mon_cmp(1, v1, s1, g1, a1, op1);
        end
    end

    typedef struct {
        logic         rst;
        logic [3:0]   rq;
        logic [31:0]  d0;
        logic [31:0]  d2;
        logic         rdy;
        logic         ev;
        logic [1:0]   es;
        logic [3:0]   eg;
        logic [31:0]  eop;
        logic [3:0]   ea;
    } vec_t;

    vec_t tbl [18];

    int exp4 [$];
    int exp1 [$];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs a constant request pattern with out_ready=1 and r<i>=i, checking grant order and spacing.
    task automatic run_stream(input logic [3:0] rq, input string name);
        int n4, n1, c4, c1;
        n4 = 0; n1 = 0; c4 = 0; c1 = 0;
        @(negedge clk);
        reset = 1'b1; req = 4'b0000; out_ready = 1'b1;
        r0 = 32'd0; r1 = 32'd1; r2 = 32'd2; r3 = 32'd3;
        repeat (2) @(negedge clk);
        reset = 1'b0; req = rq;
        for (int cyc = 0; cyc < 200 && (n4 < exp4.size() || n1 < exp1.size()); cyc++) begin
            #1;
            if (v4 && out_ready && n4 < exp4.size()) begin
                check({name, " b4 order"}, op4, 32'(exp4[n4]));
                if (n4 > 0) check({name, " b4 spacing"}, 32'(cyc - c4), 32'd2);
                c4 = cyc; n4++;
            end
            if (v1 && out_ready && n1 < exp1.size()) begin
                check({name, " b1 order"}, op1, 32'(exp1[n1]));
                if (n1 > 0) check({name, " b1 spacing"}, 32'(cyc - c1), 32'd2);
                c1 = cyc; n1++;
            end
            @(negedge clk);
        end
        check({name, " b4 transfers seen"}, 32'(n4), 32'(exp4.size()));
        check({name, " b1 transfers seen"}, 32'(n1), 32'(exp1.size()));
        req = 4'b0000;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b0001, 32'hA5A5_0000, 32'h0,         1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,         4'b0000};
        tbl[1]  = '{1'b0, 4'b0000, 32'hA5A5_0000, 32'h0,         1'b1, 1'b1, 2'd0, 4'b0001, 32'hA5A5_0000, 4'b0001};
        tbl[2]  = '{1'b0, 4'b0000, 32'hA5A5_0000, 32'h0,         1'b1, 1'b0, 2'd0, 4'b0000, 32'hA5A5_0000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 4'b0000, 32'hA5A5_0000, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 4'b0100, 32'h1234_5678, 4'b0000};
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = tbl[4];
        tbl[8]  = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd2, 4'b0100, 32'h1234_5678, 4'b0100};
        tbl[9]  = '{1'b0, 4'b0000, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 4'b0000, 32'h1234_5678, 4'b0000};
        tbl[10] = '{1'b0, 4'b0001, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h1234_5678, 4'b0000};
        tbl[11] = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0, 4'b0001, 32'hA5A5_0000, 4'b0000};
        tbl[12] = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hA5A5_0000, 4'b0001};
        tbl[13] = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 4'b0000, 32'hA5A5_0000, 4'b0000};
        tbl[14] = '{1'b0, 4'b0100, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 4'b0100, 32'hDEAD_BEEF, 4'b0000};
        tbl[15] = '{1'b1, 4'b1111, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 4'b0100, 32'hDEAD_BEEF, 4'b0000};
        tbl[16] = '{1'b0, 4'b1111, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,         4'b0000};
        tbl[17] = '{1'b0, 4'b1111, 32'hA5A5_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hA5A5_0000, 4'b0001};

        reset = 1'b1; req = 4'b0000; out_ready = 1'b1;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            reset = tbl[i].rst; req = tbl[i].rq; r0 = tbl[i].d0; r2 = tbl[i].d2;
            r1 = '0; r3 = '0; out_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d valid", i),   32'(v4), 32'(tbl[i].ev));
            check($sformatf("vec%0d select", i),  32'(s4), 32'(tbl[i].es));
            check($sformatf("vec%0d grant", i),   32'(g4), 32'(tbl[i].eg));
            check($sformatf("vec%0d operand", i), op4,     tbl[i].eop);
            check($sformatf("vec%0d ack", i),     32'(a4), 32'(tbl[i].ea));
        end

        exp4 = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        exp1 = '{0,1,2,3,0,1,2,3,0};
        run_stream(4'b1111, "contention");

        exp4 = '{0,0,0,0,3,3,3,3,0};
        exp1 = '{0,3,0,3,0,3};
        run_stream(4'b1001, "wrap");

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom);
            r0        = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #3;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
